// File: rtl/led_panel_bcm.sv
// HUB75-style LED panel driver: a dual-half RGB frame buffer scanned out with
// binary-coded modulation, one bit-plane per shift/latch/display pass.

module led_panel_bcm_lane #(
  parameter  int COLS     = 32,
  parameter  int ROW_BITS = 2,
  parameter  int BPP      = 2,
  localparam int CW       = $clog2(COLS),
  localparam int PW       = (BPP > 1) ? $clog2(BPP) : 1,
  localparam int DEPTH    = (1 << ROW_BITS) * COLS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ROW_BITS+CW-1:0] wr_addr,
  input  logic [3*BPP-1:0]       wr_data,
  input  logic [ROW_BITS+CW-1:0] rd_addr,
  input  logic [PW-1:0]          plane,
  input  logic                   load,
  input  logic                   clr,
  output logic [2:0]             rgb
);
  localparam int PADW = 1 << PW;

  logic [3*BPP-1:0] mem [DEPTH];
  logic [3*BPP-1:0] word;
  logic [PADW-1:0]  r_pad, g_pad, b_pad;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Channels are padded to a power-of-two width so the plane index always
  // addresses a full-width vector, including the BPP=1 and BPP=3 cases.
  assign word  = mem[rd_addr];
  assign r_pad = PADW'(word[3*BPP-1:2*BPP]);
  assign g_pad = PADW'(word[2*BPP-1:BPP]);
  assign b_pad = PADW'(word[BPP-1:0]);

  always_ff @(posedge clk) begin
    if (reset)     rgb <= '0;
    else if (load) rgb <= {r_pad[plane], g_pad[plane], b_pad[plane]};
    else if (clr)  rgb <= '0;
  end
endmodule

module led_panel_bcm #(
  parameter  int COLS       = 32,
  parameter  int ROW_BITS   = 2,
  parameter  int BPP        = 2,
  parameter  int PAUSE_BASE = 4,
  localparam int CW         = $clog2(COLS),
  localparam int AW         = 1 + ROW_BITS + CW,
  localparam int PW         = (BPP > 1) ? $clog2(BPP) : 1,
  localparam int DW         = $clog2((PAUSE_BASE << (BPP - 1)) + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [3*BPP-1:0]    wr_data,
  output logic                r0,
  output logic                g0,
  output logic                b0,
  output logic                r1,
  output logic                g1,
  output logic                b1,
  output logic                sclk,
  output logic                latch,
  output logic                blank,
  output logic [ROW_BITS-1:0] row_addr,
  output logic                frame_start
);
  typedef enum logic [2:0] {SHIFT_LO, SHIFT_HI, BLANK, LATCH, DISPLAY} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       col;
  logic [ROW_BITS-1:0] shift_row;
  logic [PW-1:0]       plane;
  logic [DW-1:0]       delay;
  logic                load, clr;
  logic                col_last, plane_last, delay_done;
  logic [1:0][2:0]     lane_rgb;

  assign col_last   = col == CW'(COLS - 1);
  assign plane_last = plane == PW'(BPP - 1);
  assign delay_done = delay == '0;

  always_ff @(posedge clk) begin
    if (reset) state <= SHIFT_LO;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    clr       = 1'b0;
    case (state)
      SHIFT_LO: begin
        load      = 1'b1;
        state_nxt = SHIFT_HI;
      end
      SHIFT_HI: state_nxt = col_last ? BLANK : SHIFT_LO;
      BLANK: begin
        clr       = 1'b1;
        state_nxt = LATCH;
      end
      LATCH:    state_nxt = DISPLAY;
      DISPLAY:  if (delay_done) state_nxt = SHIFT_LO;
      default:  state_nxt = SHIFT_LO;
    endcase
  end

  // Scan counters: col steps per shifted pixel, plane/row step after display.
  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      shift_row <= '0;
      plane     <= '0;
      delay     <= '0;
    end else begin
      case (state)
        SHIFT_HI: col <= col_last ? '0 : col + 1'b1;
        LATCH:    delay <= DW'((PAUSE_BASE << plane) - 1);
        DISPLAY: begin
          if (!delay_done) begin
            delay <= delay - 1'b1;
          end else if (plane_last) begin
            plane     <= '0;
            shift_row <= shift_row + 1'b1;
          end else begin
            plane <= plane + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // blank is re-asserted as soon as shifting resumes so the low window is
  // exactly the DISPLAY length and never overlaps new data on the lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk        <= 1'b0;
      latch       <= 1'b0;
      blank       <= 1'b1;
      row_addr    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      latch       <= 1'b0;
      case (state)
        SHIFT_LO: begin
          sclk        <= 1'b0;
          blank       <= 1'b1;
          frame_start <= col == '0 && shift_row == '0 && plane == '0;
        end
        SHIFT_HI: begin
          sclk  <= 1'b1;
          blank <= 1'b1;
        end
        BLANK: begin
          sclk  <= 1'b0;
          blank <= 1'b1;
        end
        LATCH: begin
          latch    <= 1'b1;
          row_addr <= shift_row;
        end
        DISPLAY:  blank <= 1'b0;
        default: ;
      endcase
    end
  end

  for (genvar h = 0; h < 2; h++) begin : g_lane
    led_panel_bcm_lane #(
      .COLS     (COLS),
      .ROW_BITS (ROW_BITS),
      .BPP      (BPP)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en && wr_addr[AW-1] == 1'(h)),
      .wr_addr (wr_addr[AW-2:0]),
      .wr_data (wr_data),
      .rd_addr ({shift_row, col}),
      .plane   (plane),
      .load    (load),
      .clr     (clr),
      .rgb     (lane_rgb[h])
    );
  end

  assign {r0, g0, b0} = lane_rgb[0];
  assign {r1, g1, b1} = lane_rgb[1];
endmodule
